// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive-path APB controller: register
// offsets, CTRL/STATUS bit positions, config encodings and the APB FSM states.
package uart_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DATA   = 2'd2;
  localparam logic [1:0] REG_ERRCLR = 2'd3;

  localparam int CTRL_RX_EN     = 0;
  localparam int CTRL_PARITY_LO = 1;
  localparam int CTRL_BAUD_LO   = 3;
  localparam int CTRL_IE_DATA   = 5;
  localparam int CTRL_IE_ERR    = 6;
  localparam int CTRL_W         = 7;

  localparam int STAT_EMPTY    = 0;
  localparam int STAT_FULL     = 1;
  localparam int STAT_STICKY_LO = 2;
  localparam int STICKY_W      = 6;  // STATUS[7:2]: fifo_err, line_err[2:0], overrun, underrun

  localparam logic [1:0] PARITY_NONE  = 2'b00;
  localparam logic [1:0] PARITY_ODD   = 2'b01;
  localparam logic [1:0] PARITY_EVEN  = 2'b10;
  localparam logic [1:0] PARITY_STICK = 2'b11;

  localparam logic [1:0] BAUD_2400  = 2'b00;
  localparam logic [1:0] BAUD_4800  = 2'b01;
  localparam logic [1:0] BAUD_9600  = 2'b10;
  localparam logic [1:0] BAUD_19200 = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_POP_WAIT
  } apb_state_e;

endpackage

// File: rtl/uart_rx_err_sticky.sv
// Sticky error capture with write-one-to-clear and the registered level
// interrupt. A set in the same cycle as its clear leaves the bit set.
module uart_rx_err_sticky
  import uart_pkg::*;
(
  input  logic                clock,
  input  logic                reset_n,
  input  logic                rx_en,
  input  logic                rx_done_flag,
  input  logic [2:0]          error_flag,
  input  logic                fifo_full,
  input  logic                fifo_empty,
  input  logic                fifo_err,
  input  logic                underrun_set,
  input  logic                clr_we,
  input  logic [STICKY_W-1:0] clr_mask,
  input  logic                ie_data,
  input  logic                ie_err,
  output logic [STICKY_W-1:0] sticky,
  output logic                irq
);

  logic [STICKY_W-1:0] set_vec;
  logic [STICKY_W-1:0] sticky_next;
  logic                irq_next;

  // Line errors and overrun are only meaningful while the receiver runs.
  always_comb begin
    set_vec      = '0;
    set_vec[0]   = fifo_err;
    set_vec[3:1] = (rx_en && rx_done_flag) ? error_flag : 3'b000;
    set_vec[4]   = rx_en & rx_done_flag & fifo_full;
    set_vec[5]   = underrun_set;
    sticky_next  = (sticky & ~(clr_we ? clr_mask : '0)) | set_vec;
    irq_next     = (ie_data & ~fifo_empty) | (ie_err & (|sticky));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sticky <= '0;
      irq    <= 1'b0;
    end else begin
      sticky <= sticky_next;
      irq    <= irq_next;
    end
  end

endmodule

// File: rtl/uart_rx_apb_ctrl.sv
// APB3 slave fronting the UART receive path: CTRL/STATUS/DATA/ERRCLR registers,
// bus-driven FIFO pops with one wait state, sticky errors and interrupt.
module uart_rx_apb_ctrl
  import uart_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic [7:0]        rx_data,
  input  logic              fifo_empty,
  input  logic              fifo_full,
  input  logic              fifo_err,
  input  logic              rx_done_flag,
  input  logic [2:0]        error_flag,
  output logic              fifo_pop,
  output logic [1:0]        parity_type,
  output logic [1:0]        baud_rate,
  output logic              rx_enable,
  output logic              irq
);

  apb_state_e          state, state_next;
  logic [CTRL_W-1:0]   ctrl;
  logic [STICKY_W-1:0] sticky;
  logic [1:0]          reg_sel;
  logic                ctrl_we, clr_we, underrun_set;
  logic                unused_bits;

  assign reg_sel     = paddr[3:2];
  assign unused_bits = ^{paddr, pwdata};

  assign rx_enable   = ctrl[CTRL_RX_EN];
  assign parity_type = ctrl[CTRL_PARITY_LO +: 2];
  assign baud_rate   = ctrl[CTRL_BAUD_LO +: 2];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      ctrl  <= '0;
    end else begin
      state <= state_next;
      if (ctrl_we) ctrl <= pwdata[CTRL_W-1:0];
    end
  end

  always_comb begin
    state_next   = state;
    pready       = 1'b0;
    pslverr      = 1'b0;
    prdata       = '0;
    fifo_pop     = 1'b0;
    ctrl_we      = 1'b0;
    clr_we       = 1'b0;
    underrun_set = 1'b0;
    case (state)
      S_IDLE: begin
        if (psel && !penable) state_next = S_ACCESS;
      end
      S_ACCESS: begin
        if (!psel) begin
          state_next = S_IDLE;
        end else if (penable) begin
          if (!pwrite && reg_sel == REG_DATA && !fifo_empty) begin
            fifo_pop   = 1'b1;
            state_next = S_POP_WAIT;
          end else begin
            pready     = 1'b1;
            state_next = S_IDLE;
            if (pwrite) begin
              case (reg_sel)
                REG_CTRL:   ctrl_we = 1'b1;
                REG_ERRCLR: clr_we  = 1'b1;
                default:    pslverr = 1'b1;
              endcase
            end else begin
              case (reg_sel)
                REG_CTRL:   prdata[CTRL_W-1:0] = ctrl;
                REG_STATUS: prdata[7:0] = {sticky, fifo_full, fifo_empty};
                REG_DATA: begin
                  pslverr      = 1'b1;
                  underrun_set = 1'b1;
                end
                default:    pslverr = 1'b1;
              endcase
            end
          end
        end
      end
      S_POP_WAIT: begin
        // A dropped psel abandons the transfer; the popped byte is discarded.
        state_next = S_IDLE;
        if (psel) begin
          pready      = 1'b1;
          prdata[7:0] = rx_data;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  uart_rx_err_sticky u_sticky (
    .clock        (clock),
    .reset_n      (reset_n),
    .rx_en        (ctrl[CTRL_RX_EN]),
    .rx_done_flag (rx_done_flag),
    .error_flag   (error_flag),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .fifo_err     (fifo_err),
    .underrun_set (underrun_set),
    .clr_we       (clr_we),
    .clr_mask     (pwdata[STAT_STICKY_LO +: STICKY_W]),
    .ie_data      (ctrl[CTRL_IE_DATA]),
    .ie_err       (ctrl[CTRL_IE_ERR]),
    .sticky       (sticky),
    .irq          (irq)
  );

endmodule

// File: tb/tb_uart_rx_apb_ctrl.sv
// Self-checking bench: register vector table plus hand-written sequences for
// pops, sticky errors, interrupts, psel abort and reset during a pop.
module tb_uart_rx_apb_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [3:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [7:0]  rx_data = '0;
  logic        fifo_empty = 1'b1, fifo_full = 1'b0, fifo_err = 1'b0;
  logic        rx_done_flag = 1'b0;
  logic [2:0]  error_flag = '0;
  logic        fifo_pop;
  logic [1:0]  parity_type, baud_rate;
  logic        rx_enable, irq;

  int checks = 0;
  int errors = 0;
  int pop_cnt = 0;
  int pop_bad = 0;
  logic [7:0] fifo_q[$];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          waits;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
    int          waits;
  } vec_t;
  vec_t vecs[14];

  uart_rx_apb_ctrl #(.ADDR_W(4), .DATA_W(32)) dut (
    .clock(clock), .reset_n(reset_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .rx_data(rx_data), .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_err(fifo_err),
    .rx_done_flag(rx_done_flag), .error_flag(error_flag), .fifo_pop(fifo_pop),
    .parity_type(parity_type), .baud_rate(baud_rate), .rx_enable(rx_enable), .irq(irq)
  );

  always #5 clock = ~clock;

  // FIFO model: popped byte appears on rx_data the cycle after fifo_pop.
  always @(posedge clock) begin
    if (fifo_pop) begin
      pop_cnt++;
      if (fifo_q.size() > 0) rx_data <= fifo_q.pop_front();
      else pop_bad++;
    end
    fifo_empty <= (fifo_q.size() == 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apb_xfer(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                          input logic [31:0] er, input logic ee, input int ew,
                          input logic [2:0] inj);
    exp_t e;
    logic [31:0] got_rd;
    logic got_err;
    int waits;
    bit done;
    e.rdata = er; e.err = ee; e.waits = ew;
    sb_q.push_back(e);
    @(posedge clock); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    @(posedge clock); #1;
    penable = 1'b1;
    if (inj != 3'b000) begin
      rx_done_flag = 1'b1;
      error_flag   = inj;
    end
    waits = 0; done = 0; got_rd = '0; got_err = 1'b0;
    while (!done && waits <= 4) begin
      @(negedge clock);
      if (pready) begin
        done = 1; got_rd = prdata; got_err = pslverr;
      end
      @(posedge clock); #1;
      rx_done_flag = 1'b0;
      error_flag   = 3'b000;
      if (!done) waits++;
    end
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    e = sb_q.pop_front();
    $display("apb %s addr=0x%0h wdata=0x%0h rdata=0x%0h err=%0b waits=%0d",
             wr ? "WR" : "RD", addr, wd, got_rd, got_err, waits);
    if (!done) begin
      chk("pready_timeout", 32'(waits), 32'(e.waits));
    end else begin
      chk("prdata", got_rd, e.rdata);
      chk("pslverr", {31'b0, got_err}, {31'b0, e.err});
      chk("wait_states", 32'(waits), 32'(e.waits));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    vecs[0]  = '{1'b0, 4'h0, 32'h0,        32'h00, 1'b0, 0};
    vecs[1]  = '{1'b1, 4'h0, 32'h1B,       32'h00, 1'b0, 0};
    vecs[2]  = '{1'b0, 4'h0, 32'h0,        32'h1B, 1'b0, 0};
    vecs[3]  = '{1'b0, 4'h4, 32'h0,        32'h01, 1'b0, 0};
    vecs[4]  = '{1'b1, 4'h4, 32'h55,       32'h00, 1'b1, 0};
    vecs[5]  = '{1'b1, 4'h8, 32'h12,       32'h00, 1'b1, 0};
    vecs[6]  = '{1'b0, 4'hC, 32'h0,        32'h00, 1'b1, 0};
    vecs[7]  = '{1'b0, 4'h8, 32'h0,        32'h00, 1'b1, 0};
    vecs[8]  = '{1'b0, 4'h4, 32'h0,        32'h81, 1'b0, 0};
    vecs[9]  = '{1'b1, 4'hC, 32'h80,       32'h00, 1'b0, 0};
    vecs[10] = '{1'b0, 4'h4, 32'h0,        32'h01, 1'b0, 0};
    vecs[11] = '{1'b1, 4'h0, 32'hFFFFFF80, 32'h00, 1'b0, 0};
    vecs[12] = '{1'b0, 4'h0, 32'h0,        32'h00, 1'b0, 0};
    vecs[13] = '{1'b1, 4'h0, 32'h1B,       32'h00, 1'b0, 0};

    repeat (3) @(posedge clock);
    #1;
    chk("reset_pready", {31'b0, pready}, 32'h0);
    chk("reset_ctrl_outs", {26'b0, rx_enable, parity_type, baud_rate, irq}, 32'h0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].rd, vecs[i].err, vecs[i].waits, 3'b000);
      if (vecs[i].wr && vecs[i].addr == 4'h0) begin
        chk("cfg_rx_enable", {31'b0, rx_enable}, {31'b0, vecs[i].wd[0]});
        chk("cfg_parity", {30'b0, parity_type}, {30'b0, vecs[i].wd[2:1]});
        chk("cfg_baud", {30'b0, baud_rate}, {30'b0, vecs[i].wd[4:3]});
      end
    end

    // Single DATA pop with one wait state.
    fifo_q.push_back(8'hA5);
    p0 = pop_cnt;
    apb_xfer(1'b0, 4'h8, 32'h0, 32'hA5, 1'b0, 1, 3'b000);
    chk("pop_once", 32'(pop_cnt - p0), 32'd1);

    // Line error + overrun capture and delayed irq.
    apb_xfer(1'b1, 4'h0, 32'h41, 32'h0, 1'b0, 0, 3'b000);
    @(posedge clock); #1;
    fifo_full = 1'b1; rx_done_flag = 1'b1; error_flag = 3'b101;
    @(posedge clock); #1;
    fifo_full = 1'b0; rx_done_flag = 1'b0; error_flag = 3'b000;
    chk("irq_not_yet", {31'b0, irq}, 32'h0);
    @(posedge clock); #1;
    chk("irq_err", {31'b0, irq}, 32'h1);
    apb_xfer(1'b0, 4'h4, 32'h0, 32'h69, 1'b0, 0, 3'b000);

    // W1C of line+overrun while a new parity error arrives: parity stays set.
    apb_xfer(1'b1, 4'hC, 32'h78, 32'h0, 1'b0, 0, 3'b001);
    apb_xfer(1'b0, 4'h4, 32'h0, 32'h09, 1'b0, 0, 3'b000);
    chk("irq_still_err", {31'b0, irq}, 32'h1);
    apb_xfer(1'b1, 4'hC, 32'hFC, 32'h0, 1'b0, 0, 3'b000);
    repeat (2) @(posedge clock);
    #1;
    chk("irq_cleared", {31'b0, irq}, 32'h0);

    // rx_en=0 suppresses line/overrun capture; fifo_err still sticks.
    apb_xfer(1'b1, 4'h0, 32'h40, 32'h0, 1'b0, 0, 3'b000);
    @(posedge clock); #1;
    fifo_full = 1'b1; rx_done_flag = 1'b1; error_flag = 3'b111;
    @(posedge clock); #1;
    fifo_full = 1'b0; rx_done_flag = 1'b0; error_flag = 3'b000;
    apb_xfer(1'b0, 4'h4, 32'h0, 32'h01, 1'b0, 0, 3'b000);
    @(posedge clock); #1;
    fifo_err = 1'b1;
    @(posedge clock); #1;
    fifo_err = 1'b0;
    apb_xfer(1'b0, 4'h4, 32'h0, 32'h05, 1'b0, 0, 3'b000);
    apb_xfer(1'b1, 4'hC, 32'h04, 32'h0, 1'b0, 0, 3'b000);
    apb_xfer(1'b0, 4'h4, 32'h0, 32'h01, 1'b0, 0, 3'b000);

    // ie_data: irq while non-empty, drained by DATA reads.
    apb_xfer(1'b1, 4'h0, 32'h20, 32'h0, 1'b0, 0, 3'b000);
    fifo_q.push_back(8'h11); fifo_q.push_back(8'h22); fifo_q.push_back(8'h33);
    repeat (3) @(posedge clock);
    #1;
    chk("irq_data", {31'b0, irq}, 32'h1);
    p0 = pop_cnt;
    apb_xfer(1'b0, 4'h8, 32'h0, 32'h11, 1'b0, 1, 3'b000);
    apb_xfer(1'b0, 4'h8, 32'h0, 32'h22, 1'b0, 1, 3'b000);
    chk("irq_data_mid", {31'b0, irq}, 32'h1);
    apb_xfer(1'b0, 4'h8, 32'h0, 32'h33, 1'b0, 1, 3'b000);
    chk("pop_count3", 32'(pop_cnt - p0), 32'd3);
    repeat (2) @(posedge clock);
    #1;
    chk("irq_drained", {31'b0, irq}, 32'h0);

    // psel dropped during POP_WAIT: no completion, single pop, FSM back to IDLE.
    apb_xfer(1'b1, 4'h0, 32'h00, 32'h0, 1'b0, 0, 3'b000);
    fifo_q.push_back(8'h77);
    p0 = pop_cnt;
    @(posedge clock); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 4'h8;
    @(posedge clock); #1;
    penable = 1'b1;
    @(posedge clock); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge clock);
    chk("abort_pready", {31'b0, pready}, 32'h0);
    @(posedge clock); #1;
    chk("abort_pop_once", 32'(pop_cnt - p0), 32'd1);
    apb_xfer(1'b0, 4'h4, 32'h0, 32'h01, 1'b0, 0, 3'b000);

    // Reset asserted in POP_WAIT clears outputs at once.
    apb_xfer(1'b1, 4'h0, 32'h3F, 32'h0, 1'b0, 0, 3'b000);
    fifo_q.push_back(8'h5A);
    @(posedge clock); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 4'h8;
    @(posedge clock); #1;
    penable = 1'b1;
    @(posedge clock); #1;
    chk("popwait_prdata", prdata, 32'h5A);
    reset_n = 1'b0;
    #1;
    chk("rst_pready", {31'b0, pready}, 32'h0);
    chk("rst_prdata", prdata, 32'h0);
    chk("rst_outs", {25'b0, fifo_pop, pslverr, rx_enable, parity_type, baud_rate}, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    psel = 1'b0; penable = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    apb_xfer(1'b0, 4'h0, 32'h0, 32'h00, 1'b0, 0, 3'b000);

    chk("pop_of_empty_fifo", 32'(pop_bad), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_apb_ctrl.md
Name: uart_rx_apb_ctrl

Overview:
APB3 slave controller that configures and sequences the UART receive path: drives parity_type/baud_rate, pops the Rx FIFO on DATA register reads, accumulates sticky line/FIFO errors and raises a level interrupt. Sits between the APB bus and the UART receive top, and replaces the free-running FIFO pop with bus-driven reads.

Parameters:
ADDR_W, 4, APB address width (byte address; registers word-aligned).
DATA_W, 32, APB data width; unused upper bits read 0, writes ignored.

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
psel  in  1  APB select
penable  in  1  APB enable
pwrite  in  1  APB write
paddr  in  ADDR_W  APB address
pwdata  in  DATA_W  APB write data
prdata  out  DATA_W  APB read data
pready  out  1  APB ready
pslverr  out  1  APB error
rx_data  in  8  FIFO head data, valid the cycle after fifo_pop
fifo_empty  in  1  Rx FIFO empty
fifo_full  in  1  Rx FIFO full
fifo_err  in  1  FIFO push/pop error pulse
rx_done_flag  in  1  frame received pulse
error_flag  in  3  {stop, start, parity} error for current frame, valid with rx_done_flag
fifo_pop  out  1  one-cycle FIFO pop strobe
parity_type  out  2  to receiver
baud_rate  out  2  to baud generator
rx_enable  out  1  receiver enable
irq  out  1  level interrupt

Behaviour:
- Clock/reset: one clock `clock`; reset_n asynchronous active-low. On reset: all outputs 0, CTRL=0, sticky bits=0, FSM=IDLE.
- Register map (paddr[3:2]):
  - 0x0 CTRL RW: [0] rx_en, [2:1] parity_type, [4:3] baud_rate, [5] ie_data, [6] ie_err.
  - 0x4 STATUS RO: [0] fifo_empty, [1] fifo_full, [2] fifo_err_s, [5:3] line_err_s, [6] overrun_s, [7] underrun_s.
  - 0x8 DATA RO: [7:0] popped byte.
  - 0xC ERRCLR WO: W1C for STATUS[7:2].
- Config outputs are driven directly from CTRL bits, so a write takes effect the cycle after the ACCESS phase.
- FSM states: IDLE, ACCESS, POP_WAIT.
  - IDLE: psel & ~penable -> ACCESS.
  - ACCESS, write / non-DATA read / DATA read with fifo_empty=1: pready=1 this cycle -> IDLE (zero wait states).
  - ACCESS, DATA read with fifo_empty=0: fifo_pop=1 for exactly one cycle, pready=0 -> POP_WAIT.
  - POP_WAIT: prdata={24'b0, rx_data}, pready=1 -> IDLE. DATA read latency is one wait state.
- DATA read while empty: prdata=0, pslverr=1, underrun_s set. No pop is issued.
- Writes to DATA or STATUS, and reads of ERRCLR: pslverr=1, no state change.
- Unmapped address: not possible with ADDR_W=4.
- pready/pslverr/prdata are valid only in the completing cycle; prdata=0 otherwise.
- Sticky capture (every cycle, independent of FSM):
  - rx_done_flag & |error_flag: line_err_s |= error_flag.
  - rx_done_flag & fifo_full: overrun_s set.
  - fifo_err: fifo_err_s set.
  - Same-cycle set and W1C clear: set wins.
- rx_en=0: error/overrun capture is suppressed; FIFO can still be drained via DATA.
- irq = (ie_data & ~fifo_empty) | (ie_err & |STATUS[7:2]); registered, 1-cycle delay.
- fifo_pop is never asserted twice for one transfer. psel dropping mid-transfer (protocol violation) returns the FSM to IDLE and cancels any pending POP_WAIT capture.

Decomposition:
- Shared package uart_pkg: register offsets, CTRL/STATUS bit-index constants, parity and baud encodings, FSM state typedef.
- One natural sub-module: uart_rx_err_sticky (sticky set/W1C logic and irq generation). The APB FSM and register file stay in the top.

Test Plan:
- Reset mid-POP_WAIT: assert reset_n=0 -> all outputs 0 immediately; after release CTRL reads 0x00.
- Write CTRL=0x1B -> next cycle rx_en=1, parity_type=2'b01, baud_rate=2'b11; read CTRL returns 0x1B with pready=1 on the first ACCESS cycle.
- FIFO holds 0xA5, read DATA -> fifo_pop high for exactly 1 cycle, pready high on the 2nd ACCESS cycle, prdata=0x000000A5, pslverr=0.
- Empty FIFO, read DATA -> pready=1 with no wait, prdata=0, pslverr=1, STATUS[7]=1; write ERRCLR=0x80 -> STATUS[7]=0.
- rx_en=1, ie_err=1, rx_done_flag with error_flag=3'b101 while fifo_full=1 -> STATUS[5:3]=101, STATUS[6]=1, irq=1 one cycle later; W1C in the same cycle as a new error leaves the bit set.
- ie_data=1, FIFO non-empty -> irq=1; drain via DATA reads until fifo_empty -> irq=0 one cycle later.
